store_align_unit: RTL
=====================

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 4, store-queue entries; power of two, at least 2.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_valid_i  input  1  store request present.
REQ-007 req_ready_o  output  1  queue can accept a request.
REQ-008 req_addr_i  input  ADDR_W  byte address of the store.
REQ-009 req_data_i  input  DATA_W  store data, right-justified.
REQ-010 req_size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-011 mem_valid_o  output  1  memory write beat present.
REQ-012 mem_ready_i  input  1  memory accepts the beat.
REQ-013 mem_addr_o  output  ADDR_W  beat address, aligned to DATA_W/8.
REQ-014 mem_data_o  output  DATA_W  lane-aligned write data.
REQ-015 mem_strb_o  output  DATA_W/8  byte-lane write strobes.
REQ-016 err_o  output  1  one-cycle pulse when an illegal size is rejected.
REQ-017 count_o  output  $clog2(DEPTH)+1  number of queued entries, excluding the entry in issue.

Function
REQ-018 Terms: NB = DATA_W/8; off = req_addr_i mod NB; bytes = 1, 2, 4 or 8 per req_size_i.
REQ-019 Size 11 with DATA_W=32 is illegal: handshake completes, entry is discarded, err_o pulses the next cycle.
REQ-020 Handshake on each port completes only when valid and ready are both high in the same cycle.
REQ-021 req_ready_o = (count_o < DEPTH); no same-cycle bypass when full, even if a pop occurs that cycle.
REQ-022 Accepted legal requests are pushed into a FIFO in order; stores issue to memory strictly in acceptance order.
REQ-023 Issue FSM states: IDLE, BEAT0, BEAT1.
REQ-024 IDLE -> BEAT0: at the next edge when the FIFO is non-empty; the head is popped into the issue register.
REQ-025 Minimum latency from request handshake at edge N to mem_valid_o high is one cycle: mem_valid_o is high after edge N+1.
REQ-026 BEAT0 outputs:
  - mem_addr_o = addr with low log2(NB) bits cleared
  - mem_data_o = (data masked to bytes) << 8*off, truncated to DATA_W
  - mem_strb_o = ((1<<bytes)-1) << off, low NB bits
REQ-027 Lanes without a strobe SHALL drive zero on mem_data_o.
REQ-028 If off+bytes <= NB: on the beat handshake, BEAT0 -> IDLE, or -> BEAT0 directly with the next head if the FIFO is non-empty.
REQ-029 If off+bytes > NB (misaligned, crossing): BEAT0 handshake -> BEAT1, which outputs:
  - mem_addr_o = aligned addr + NB, wrapping modulo 2^ADDR_W
  - mem_data_o = the remaining upper bytes in lanes 0 upward
  - mem_strb_o = the remaining strobe bits
REQ-030 A BEAT1 handshake leaves BEAT1 with the same next-state rule as REQ-028.
REQ-031 While mem_valid_o is high and mem_ready_i is low, mem_addr_o, mem_data_o and mem_strb_o SHALL hold stable.
REQ-032 Push and pop in the same cycle leave count_o unchanged; FIFO pointers wrap modulo DEPTH.
REQ-033 mem_valid_o SHALL be low in IDLE.

Reset
REQ-034 When rst_i is high at an edge:
  - FSM -> IDLE; FIFO emptied; an in-flight beat or a pending BEAT1 is abandoned
  - mem_valid_o=0, mem_addr_o=0, mem_data_o=0, mem_strb_o=0, err_o=0, count_o=0, req_ready_o=1
REQ-035 Requests presented while rst_i is high SHALL be ignored.

Verification
REQ-036 DATA_W=32, addr 0x1003, byte, data 0xAB -> one beat: addr 0x1000, data 0xAB000000, strb 1000.
REQ-037 DATA_W=32, addr 0x2006, word, data 0x11223344, mem_ready_i=1 -> two beats:
  - beat 1: addr 0x2004, data 0x33440000, strb 1100
  - beat 2: addr 0x2008, data 0x00001122, strb 0011
REQ-038 DEPTH=4, mem_ready_i=0, 5 requests offered -> 1 enters issue, 4 queue, req_ready_o=0, count_o=4; raise mem_ready_i -> issue in order, count_o decrements once per pop.
REQ-039 DATA_W=32, dword request -> err_o pulses for one cycle, no memory beat, count_o unchanged.
REQ-040 Reset asserted in BEAT1 with mem_ready_i=0 and 2 entries queued -> next cycle mem_valid_o=0, count_o=0; a later store issues normally.
REQ-041 mem_ready_i toggled randomly -> outputs stable while stalled; beat sequence matches a reference model byte for byte.

Source files
------------

// File: rtl/store_align_unit.sv
// Store queue with byte-lane alignment: buffers store requests in order and
// issues each as one or two lane-aligned, strobed memory write beats.
module store_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_W-1:0]         req_addr_i,
  input  logic [DATA_W-1:0]         req_data_i,
  input  logic [1:0]                req_size_i,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_data_o,
  output logic [DATA_W/8-1:0]       mem_strb_o,
  output logic                      err_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [1:0]        fifo_size_q [DEPTH];
  logic [1:0]        fifo_size_d [DEPTH];

  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
  logic [DATA_W-1:0] iss_data_q, iss_data_d;
  logic [1:0]        iss_size_q, iss_size_d;

  logic              accept, illegal, push, pop, beat_done, advance, crossing;
  logic [3:0]        nbytes;
  logic [LB-1:0]     off;
  logic [NB-1:0]     bmask;
  logic [DATA_W-1:0] data_m;
  logic [2*NB-1:0]   wide_strb;
  logic [2*DATA_W-1:0] wide_data;
  logic [ADDR_W-1:0] aligned;

  assign req_ready_o = (count_q < CW'(DEPTH));
  assign mem_valid_o = (state_q != S_IDLE);
  assign count_o     = count_q;
  assign err_o       = err_q;

  // Lane formatting of the issue register. Shifting into a double-width
  // window gives BEAT0 in the low half and the crossing remainder in the high half.
  always_comb begin
    case (iss_size_q)
      2'b00:   nbytes = 4'd1;
      2'b01:   nbytes = 4'd2;
      2'b10:   nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
    off    = iss_addr_q[LB-1:0];
    bmask  = '0;
    data_m = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      bmask[i] = (i < 32'(nbytes));
      if (bmask[i]) data_m[8*i +: 8] = iss_data_q[8*i +: 8];
    end
    wide_strb = {{NB{1'b0}}, bmask} << off;
    wide_data = {{DATA_W{1'b0}}, data_m} << {off, 3'b000};
    crossing  = |wide_strb[2*NB-1:NB];
    aligned   = {iss_addr_q[ADDR_W-1:LB], {LB{1'b0}}};

    mem_addr_o = '0;
    mem_data_o = '0;
    mem_strb_o = '0;
    if (state_q == S_BEAT0) begin
      mem_addr_o = aligned;
      mem_data_o = wide_data[DATA_W-1:0];
      mem_strb_o = wide_strb[NB-1:0];
    end else if (state_q == S_BEAT1) begin
      mem_addr_o = aligned + ADDR_W'(NB);
      mem_data_o = wide_data[2*DATA_W-1:DATA_W];
      mem_strb_o = wide_strb[2*NB-1:NB];
    end
  end

  always_comb begin
    accept    = req_valid_i && req_ready_o;
    illegal   = (DATA_W == 32) && (req_size_i == 2'b11);
    push      = accept && !illegal;
    err_d     = accept && illegal;
    beat_done = mem_valid_o && mem_ready_i;

    // The issue register is free when idle or when its final beat completes.
    advance = (state_q == S_IDLE) ||
              (state_q == S_BEAT0 && beat_done && !crossing) ||
              (state_q == S_BEAT1 && beat_done);
    pop = advance && (count_q != '0);

    state_d = state_q;
    if (state_q == S_BEAT0 && beat_done && crossing) state_d = S_BEAT1;
    else if (advance) state_d = pop ? S_BEAT0 : S_IDLE;

    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_size_d = fifo_size_q;
    wr_ptr_d    = wr_ptr_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = req_addr_i;
      fifo_data_d[wr_ptr_q] = req_data_i;
      fifo_size_d[wr_ptr_q] = req_size_i;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    iss_addr_d = iss_addr_q;
    iss_data_d = iss_data_q;
    iss_size_d = iss_size_q;
    rd_ptr_d   = rd_ptr_q;
    if (pop) begin
      iss_addr_d = fifo_addr_q[rd_ptr_q];
      iss_data_d = fifo_data_q[rd_ptr_q];
      iss_size_d = fifo_size_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
    fifo_size_q <= fifo_size_d;
    iss_addr_q  <= iss_addr_d;
    iss_data_q  <= iss_data_d;
    iss_size_q  <= iss_size_d;
  end

endmodule
